// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a registered borrow, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds output V, the signed overflow flag of A - B.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             V,
`endif
    output logic             Bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-2:0] partial_q;
    logic             borrow_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             outValid_q;

    logic             aBit;
    logic             bBit;
    logic             diffBit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] result_d;

    assign aBit      = aShift_q[0];
    assign bBit      = bShift_q[0];
    assign diffBit_d = aBit ^ bBit ^ borrow_q;
    assign borrow_d  = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);
    // The newest bit enters at the MSB so the final shift lands every bit in place.
    assign result_d  = {diffBit_d, partial_q};

`ifdef SERIAL_SUB_OVF_EN
    logic v_q;
    // On the last shift the operand LSBs are the original sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
        end else if (state_q == SHIFT && count_q == CW'(WIDTH - 1)) begin
            v_q <= (aBit ^ bBit) & (aBit ^ diffBit_d);
        end
    end
    assign V = v_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            partial_q  <= '0;
            borrow_q   <= 1'b0;
            count_q    <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aShift_q <= A;
                        bShift_q <= B;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    aShift_q  <= aShift_q >> 1;
                    bShift_q  <= bShift_q >> 1;
                    borrow_q  <= borrow_d;
                    partial_q <= result_d[WIDTH-1:1];
                    count_q   <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        diff_q     <= result_d;
                        bout_q     <= borrow_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign D         = diff_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), with V checks under SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             vOut;

    int compared   = 0;
    int mismatched = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
`ifdef SERIAL_SUB_OVF_EN
        .V         (vOut),
`endif
        .Bout      (Bout)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign vOut = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] expD;
        logic             expBout;
        logic             expV;
    } vector_t;

    vector_t vectors[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands, checks the SHIFT phase and latency, leaves the DUT in DONE.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int cycles;
        cycles = 0;
        while (!in_ready && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("in_ready before accept", int'(in_ready), 1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("in_ready during SHIFT", int'(in_ready), 0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("latency", cycles, WIDTH);
        checkOutput("in_ready in DONE", int'(in_ready), 0);
    endtask

    task automatic releaseResult(input logic [WIDTH-1:0] lastD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid after handshake", int'(out_valid), 0);
        checkOutput("in_ready after handshake", int'(in_ready), 1);
        checkOutput("D held after handshake", int'(D), int'(lastD));
    endtask

    initial begin
        vectors[0] = '{a: 4'd0,  b: 4'd0,  expD: 4'd0,  expBout: 1'b0, expV: 1'b0};
        vectors[1] = '{a: 4'd5,  b: 4'd3,  expD: 4'd2,  expBout: 1'b0, expV: 1'b0};
        vectors[2] = '{a: 4'd3,  b: 4'd5,  expD: 4'd14, expBout: 1'b1, expV: 1'b0};
        vectors[3] = '{a: 4'd0,  b: 4'd15, expD: 4'd1,  expBout: 1'b1, expV: 1'b0};
        vectors[4] = '{a: 4'd15, b: 4'd15, expD: 4'd0,  expBout: 1'b0, expV: 1'b0};
        vectors[5] = '{a: 4'd7,  b: 4'd8,  expD: 4'd15, expBout: 1'b1, expV: 1'b1};
        vectors[6] = '{a: 4'd8,  b: 4'd1,  expD: 4'd7,  expBout: 1'b0, expV: 1'b1};
        vectors[7] = '{a: 4'd6,  b: 4'd2,  expD: 4'd4,  expBout: 1'b0, expV: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset D", int'(D), 0);
        checkOutput("reset Bout", int'(Bout), 0);
        checkOutput("reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b);
            checkOutput($sformatf("vec%0d D", i), int'(D), int'(vectors[i].expD));
            checkOutput($sformatf("vec%0d Bout", i), int'(Bout), int'(vectors[i].expBout));
`ifdef SERIAL_SUB_OVF_EN
            checkOutput($sformatf("vec%0d V", i), int'(vOut), int'(vectors[i].expV));
`endif
            releaseResult(vectors[i].expD);
        end

        $display("[TB] backpressure sequence");
        applyStimulus(4'd9, 4'd4);
        A        = 4'd1;
        B        = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp out_valid held", int'(out_valid), 1);
            checkOutput("bp D held", int'(D), 5);
            checkOutput("bp in_ready low", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp back to IDLE", int'(in_ready), 1);
        checkOutput("bp out_valid dropped", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        checkOutput("bp second accepted", int'(in_ready), 0);
        checkOutput("bp D kept during SHIFT", int'(D), 5);
        begin
            int cycles;
            cycles = 0;
            while (!out_valid && cycles < 20) begin
                tick();
                cycles++;
            end
            checkOutput("bp second latency", cycles, WIDTH);
        end
        checkOutput("bp second D", int'(D), 0);
        checkOutput("bp second Bout", int'(Bout), 0);
        releaseResult(4'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(4'd3, 4'd5);
        releaseResult(4'd14);
        A        = 4'd12;
        B        = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort D", int'(D), 0);
        checkOutput("abort Bout", int'(Bout), 0);
        checkOutput("abort out_valid", int'(out_valid), 0);
        checkOutput("abort in_ready", int'(in_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid) seen++;
            end
            checkOutput("abort no out_valid pulse", seen, 0);
        end
        checkOutput("abort D still zero", int'(D), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
